// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared opcode constants and instruction layout for the fetch unit and decoder.
//   OP_NOP / OP_JNC / OP_JMP : opcodes the fetch unit acts on
//   instr_t                  : {op[3:0], im[3:0]} program-memory word
package fetch_unit_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JNC = 4'hE;
  localparam logic [3:0] OP_JMP = 4'hF;
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] im;
  } instr_t;
  // A jump onto its own address can never make progress, so it means "halt".
  function automatic logic is_halt(instr_t i, logic [3:0] pc);
    return i.op == OP_JMP && i.im == pc;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: program-load bus and instruction-issue bus of the fetch unit.
//   prog_we/prog_addr/prog_data : program-memory write port (driven by master)
//   op_out/im_out/valid_out     : issued instruction (driven by slave)
interface fetch_unit_if;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] op_out;
  logic [3:0] im_out;
  logic       valid_out;
  modport master (output prog_we, prog_addr, prog_data, input op_out, im_out, valid_out);
  modport slave (input prog_we, prog_addr, prog_data, output op_out, im_out, valid_out);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// pc_next: combinational next-PC and halt detection for the instruction at pc.
//   pc       : current program counter
//   instr    : instruction fetched from pc
//   carry_in : CPU carry flag (JNC branches when it is 0)
//   next_pc  : address of the following fetch
//   halt     : instruction is a jump onto itself
module pc_next
  import fetch_unit_pkg::*;
(
  input  logic [3:0] pc,
  input  instr_t     instr,
  input  logic       carry_in,
  output logic [3:0] next_pc,
  output logic       halt
);
  logic take;
  assign take    = instr.op == OP_JMP || (instr.op == OP_JNC && !carry_in);
  assign next_pc = take ? instr.im : pc + 4'd1;
  assign halt    = is_halt(instr, pc);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: 16x8 program memory plus IDLE/RUN/STEP/HALT sequencer issuing one instruction per cycle.
//   clk_cpu, reset_n     : clock and asynchronous active-low reset
//   run, step, pc_clr    : continuous run level, single-issue request, PC clear (IDLE only)
//   carry_in             : carry flag consumed by JNC in its issue cycle
//   bus (slave)          : program write port in, issued op/im/valid out
//   pc_out, halted       : address of next fetch, high while halted
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk_cpu,
  input  logic         reset_n,
  input  logic         run,
  input  logic         step,
  input  logic         pc_clr,
  input  logic         carry_in,
  fetch_unit_if.slave  bus,
  output logic [3:0]   pc_out,
  output logic         halted
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALT} state_t;
  state_t     state_q, state_d;
  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];
  logic [3:0] pc_q, pc_d, op_q, op_d, im_q, im_d;
  logic       valid_q, valid_d, halted_q, halted_d;
  logic [3:0] npc;
  logic       halt, issue, idle;
  instr_t     cur;
  assign cur = instr_t'(mem_q[pc_q]);
  pc_next u_pc_next (
    .pc      (pc_q),
    .instr   (cur),
    .carry_in(carry_in),
    .next_pc (npc),
    .halt    (halt)
  );
  always_comb begin
    idle  = state_q == S_IDLE;
    // RUN falling back to IDLE because run dropped must not issue.
    issue = (state_q == S_RUN && run) || state_q == S_STEP;
    state_d = idle ? (run ? S_RUN : step ? S_STEP : S_IDLE)
            : state_q == S_RUN ? (!run ? S_IDLE : halt ? S_HALT : S_RUN)
            : state_q == S_STEP ? S_IDLE
            : (run ? S_HALT : S_IDLE);
    pc_d     = issue ? npc : (idle && pc_clr) ? 4'd0 : pc_q;
    op_d     = issue ? cur.op : op_q;
    im_d     = issue ? cur.im : im_q;
    valid_d  = issue;
    halted_d = state_d == S_HALT;
    mem_d = mem_q;
    if (idle && bus.prog_we) mem_d[bus.prog_addr] = bus.prog_data;
  end
  always_ff @(posedge clk_cpu or negedge reset_n)
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      op_q     <= '0;
      im_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mem_q    <= '{default: 8'h00};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      im_q     <= im_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      mem_q    <= mem_d;
    end
  assign bus.op_out    = op_q;
  assign bus.im_out    = im_q;
  assign bus.valid_out = valid_q;
  assign pc_out        = pc_q;
  assign halted        = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks against a program-level model of the fetch unit.
module tb_fetch_unit;
  logic clk_cpu = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0, step = 1'b0, pc_clr = 1'b0, carry_in = 1'b0;
  logic [3:0] pc_out;
  logic halted;
  int total = 0, bad = 0;
  logic [7:0] m_mem [16];
  logic [3:0] m_pc;
  fetch_unit_if bus();
  fetch_unit dut (
    .clk_cpu (clk_cpu),
    .reset_n (reset_n),
    .run     (run),
    .step    (step),
    .pc_clr  (pc_clr),
    .carry_in(carry_in),
    .bus     (bus),
    .pc_out  (pc_out),
    .halted  (halted)
  );
  always #5 clk_cpu = ~clk_cpu;

  task automatic tick;
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic m_clear;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_pc = 4'd0;
  endtask

  // One issue by the program rules: fetch at pc, branch or increment.
  task automatic m_issue(input logic c, output logic [3:0] op, output logic [3:0] im, output logic h);
    op = m_mem[m_pc][7:4];
    im = m_mem[m_pc][3:0];
    h  = (op == 4'd15) && (im == m_pc);
    m_pc = (op == 4'd15 || (op == 4'd14 && !c)) ? im : m_pc + 4'd1;
  endtask

  task automatic do_reset;
    run = 0; step = 0; pc_clr = 0; bus.prog_we = 0;
    reset_n = 0;
    tick;
    reset_n = 1;
    tick;
    m_clear;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    bus.prog_we = 1; bus.prog_addr = a; bus.prog_data = d;
    tick;
    bus.prog_we = 0;
    m_mem[a] = d;
  endtask

  task automatic test_reset;
    reset_n = 0;
    #1;
    total++;
    if ({pc_out, bus.op_out, bus.im_out, bus.valid_out, halted} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {pc_out, bus.op_out, bus.im_out, bus.valid_out, halted});
    end
    do_reset;
    total++;
    if ({pc_out, bus.valid_out, halted} !== 6'd0) begin
      bad++;
      $display("FAIL reset_idle got=%h want=0", {pc_out, bus.valid_out, halted});
    end
  endtask

  task automatic test_run(input int n, input logic c, input string nm);
    logic [3:0] eo, ei;
    logic eh;
    carry_in = c; run = 1;
    tick;
    total++;
    if (bus.valid_out !== 1'b0) begin
      bad++;
      $display("FAIL %s_entry valid=%b want 0", nm, bus.valid_out);
    end
    for (int i = 0; i < n; i++) begin
      tick;
      m_issue(c, eo, ei, eh);
      total++;
      if ({bus.op_out, bus.im_out, bus.valid_out, pc_out} !== {eo, ei, 1'b1, m_pc}) begin
        bad++;
        $display("FAIL %s_issue%0d got op=%h im=%h v=%b pc=%h want op=%h im=%h v=1 pc=%h",
                 nm, i, bus.op_out, bus.im_out, bus.valid_out, pc_out, eo, ei, m_pc);
      end
    end
    run = 0;
    tick;
    total++;
    if ({bus.valid_out, halted, pc_out} !== {1'b0, 1'b0, m_pc}) begin
      bad++;
      $display("FAIL %s_stop got v=%b h=%b pc=%h want v=0 h=0 pc=%h", nm, bus.valid_out, halted, pc_out, m_pc);
    end
  endtask

  task automatic test_basic;
    do_reset;
    load(0, 8'h31); load(1, 8'h52); load(2, 8'h00);
    test_run(3, 0, "basic");
    total++;
    if ({bus.op_out, bus.im_out, pc_out} !== 12'h003) begin
      bad++;
      $display("FAIL basic_hold got=%h want 003", {bus.op_out, bus.im_out, pc_out});
    end
  endtask

  task automatic test_jumps;
    do_reset;
    load(0, 8'hF5); load(5, 8'h12);
    test_run(2, 0, "jmp");
    total++;
    if ({bus.op_out, bus.im_out, pc_out} !== 12'h126) begin
      bad++;
      $display("FAIL jmp_target got=%h want 126", {bus.op_out, bus.im_out, pc_out});
    end
    do_reset;
    load(0, 8'hE7);
    test_run(1, 1, "jnc_c1");
    total++;
    if (pc_out !== 4'd1) begin bad++; $display("FAIL jnc_carry1 pc=%h want 1", pc_out); end
    do_reset;
    load(0, 8'hE7);
    test_run(1, 0, "jnc_c0");
    total++;
    if (pc_out !== 4'd7) begin bad++; $display("FAIL jnc_carry0 pc=%h want 7", pc_out); end
  endtask

  task automatic test_step;
    logic [3:0] eo, ei;
    logic eh;
    int nv;
    do_reset;
    load(0, 8'h21); load(1, 8'h43);
    step = 1;
    tick;
    step = 0;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      nv += int'(bus.valid_out);
    end
    m_issue(0, eo, ei, eh);
    total++;
    if (nv != 1 || {bus.op_out, bus.im_out, pc_out} !== {eo, ei, m_pc}) begin
      bad++;
      $display("FAIL step_once got n=%0d op=%h im=%h pc=%h want n=1 op=%h im=%h pc=%h",
               nv, bus.op_out, bus.im_out, pc_out, eo, ei, m_pc);
    end
    pc_clr = 1; run = 1;
    tick;
    pc_clr = 0;
    m_pc = 0;
    total++;
    if ({pc_out, bus.valid_out} !== 5'd0) begin
      bad++;
      $display("FAIL pcclr_run got pc=%h v=%b want pc=0 v=0", pc_out, bus.valid_out);
    end
    tick;
    m_issue(0, eo, ei, eh);
    total++;
    if ({bus.op_out, bus.im_out, bus.valid_out, pc_out} !== {eo, ei, 1'b1, m_pc}) begin
      bad++;
      $display("FAIL pcclr_issue got op=%h im=%h pc=%h want op=%h im=%h pc=%h", bus.op_out, bus.im_out, pc_out, eo, ei, m_pc);
    end
    run = 0;
    tick;
  endtask

  task automatic test_halt;
    logic [3:0] eo, ei;
    logic eh;
    do_reset;
    load(4, 8'hF4);
    for (int i = 0; i < 4; i++) begin
      step = 1; tick; step = 0; tick; tick;
      m_issue(0, eo, ei, eh);
    end
    total++;
    if (pc_out !== 4'd4) begin bad++; $display("FAIL halt_steps pc=%h want 4", pc_out); end
    run = 1;
    tick;
    tick;
    total++;
    if ({bus.op_out, bus.im_out, bus.valid_out, halted, pc_out} !== {4'hF, 4'h4, 1'b1, 1'b1, 4'h4}) begin
      bad++;
      $display("FAIL halt_issue got op=%h im=%h v=%b h=%b pc=%h want op=f im=4 v=1 h=1 pc=4",
               bus.op_out, bus.im_out, bus.valid_out, halted, pc_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({bus.valid_out, halted, pc_out} !== {1'b0, 1'b1, 4'h4}) begin
        bad++;
        $display("FAIL halt_hold%0d got v=%b h=%b pc=%h want v=0 h=1 pc=4", i, bus.valid_out, halted, pc_out);
      end
    end
    run = 0;
    tick;
    total++;
    if ({bus.valid_out, halted, pc_out} !== {1'b0, 1'b0, 4'h4}) begin
      bad++;
      $display("FAIL halt_exit got v=%b h=%b pc=%h want v=0 h=0 pc=4", bus.valid_out, halted, pc_out);
    end
  endtask

  task automatic test_prog_we;
    do_reset;
    load(0, 8'h21); load(1, 8'h43);
    run = 1;
    tick;
    bus.prog_we = 1; bus.prog_addr = 1; bus.prog_data = 8'h99;
    tick;
    tick;
    bus.prog_we = 0;
    total++;
    if ({bus.op_out, bus.im_out} !== 8'h43) begin
      bad++;
      $display("FAIL we_in_run got=%h want 43", {bus.op_out, bus.im_out});
    end
    run = 0;
    tick;
    do_reset;
    bus.prog_we = 1; bus.prog_addr = 0; bus.prog_data = 8'h6A; run = 1;
    tick;
    bus.prog_we = 0;
    tick;
    total++;
    if ({bus.op_out, bus.im_out, bus.valid_out, pc_out} !== {8'h6A, 1'b1, 4'h1}) begin
      bad++;
      $display("FAIL we_at_start got op=%h im=%h v=%b pc=%h want op=6 im=a v=1 pc=1",
               bus.op_out, bus.im_out, bus.valid_out, pc_out);
    end
    run = 0;
    tick;
  endtask

  task automatic test_random(input int seed);
    logic [3:0] eo, ei;
    logic eh, c, m_halt;
    do_reset;
    for (int a = 0; a < 16; a++) load(4'(a), 8'($urandom_range(0, 255)));
    m_halt = 0;
    run = 1;
    tick;
    for (int i = 0; i < 24; i++) begin
      c = 1'($urandom_range(0, 1));
      carry_in = c;
      tick;
      total++;
      if (!m_halt) begin
        m_issue(c, eo, ei, eh);
        m_halt = eh;
        if ({bus.op_out, bus.im_out, bus.valid_out, halted, pc_out} !== {eo, ei, 1'b1, eh, m_pc}) begin
          bad++;
          $display("FAIL rand%0d_%0d got op=%h im=%h v=%b h=%b pc=%h want op=%h im=%h v=1 h=%b pc=%h",
                   seed, i, bus.op_out, bus.im_out, bus.valid_out, halted, pc_out, eo, ei, eh, m_pc);
        end
      end else if ({bus.valid_out, halted, pc_out} !== {1'b0, 1'b1, m_pc}) begin
        bad++;
        $display("FAIL rand%0d_%0d_halted got v=%b h=%b pc=%h want v=0 h=1 pc=%h",
                 seed, i, bus.valid_out, halted, pc_out, m_pc);
      end
    end
    run = 0;
    tick;
    total++;
    if ({bus.valid_out, halted, pc_out} !== {1'b0, 1'b0, m_pc}) begin
      bad++;
      $display("FAIL rand%0d_stop got v=%b h=%b pc=%h want v=0 h=0 pc=%h", seed, bus.valid_out, halted, pc_out, m_pc);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    load(0, 8'h31); load(1, 8'h52); load(2, 8'h7C);
    run = 1;
    tick; tick; tick; tick;
    #3;
    reset_n = 0;
    #1;
    total++;
    if ({pc_out, bus.op_out, bus.im_out, bus.valid_out, halted} !== 15'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want 0", {pc_out, bus.op_out, bus.im_out, bus.valid_out, halted});
    end
    run = 0;
    reset_n = 1;
    m_clear;
    test_run(2, 0, "post_reset");
  endtask

  initial begin
    bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
    test_reset;
    test_basic;
    test_jumps;
    test_step;
    test_halt;
    test_prog_we;
    for (int s = 0; s < 4; s++) test_random(s);
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk_cpu and reset_n.
REQ-002 The block SHALL have the port clk_cpu, input, 1 bit: CPU clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have the port prog_we, input, 1 bit: program-memory write strobe.
REQ-005 The block SHALL have the port prog_addr, input, 4 bits: program-memory write address.
REQ-006 The block SHALL have the port prog_data, input, 8 bits: instruction word, {op[3:0], im[3:0]}.
REQ-007 The block SHALL have the port run, input, 1 bit: level; continuous issue while high.
REQ-008 The block SHALL have the port step, input, 1 bit: single-cycle request to issue exactly one instruction.
REQ-009 The block SHALL have the port pc_clr, input, 1 bit: clears the PC to 0 while in IDLE.
REQ-010 The block SHALL have the port carry_in, input, 1 bit: CPU carry flag used for JNC.
REQ-011 The block SHALL have the port op_out, output, 4 bits: opcode to the decoder's op_in.
REQ-012 The block SHALL have the port im_out, output, 4 bits: immediate field.
REQ-013 The block SHALL have the port valid_out, output, 1 bit: op_out and im_out carry a newly issued instruction this cycle.
REQ-014 The block SHALL have the port pc_out, output, 4 bits: current program counter, which is the address of the next fetch.
REQ-015 The block SHALL have the port halted, output, 1 bit: high while in HALT.

Function
REQ-016 The block SHALL hold a 16 x 8-bit register-based program memory, written only in IDLE when prog_we=1 (mem[prog_addr] <= prog_data), and SHALL drop writes in every other state.
REQ-017 The block SHALL implement the FSM states IDLE, RUN, STEP and HALT.
REQ-018 In IDLE, the block SHALL go to RUN if run=1, otherwise to STEP if step=1, otherwise stay in IDLE; run SHALL take priority over step.
REQ-019 In IDLE with pc_clr=1, the block SHALL set the PC to 0; if pc_clr and run are both high, the PC SHALL be cleared and the state SHALL go to RUN.
REQ-020 The block SHALL define an issue in RUN and STEP as: op_out <= mem[pc][7:4], im_out <= mem[pc][3:0], valid_out <= 1, pc <= next_pc.
REQ-021 The block SHALL compute next_pc as im if op=OP_JMP, as im if op=OP_JNC and carry_in=0, and as pc+1 (4-bit, 15 wraps to 0) in all other cases.
REQ-022 The block SHALL sample carry_in in the same cycle as the issue of the JNC instruction.
REQ-023 In RUN, the block SHALL issue one instruction every cycle; when run=0 it SHALL go to IDLE without issuing, keeping the PC.
REQ-024 In STEP, the block SHALL issue exactly one instruction and then return to IDLE.
REQ-025 The block SHALL detect halt when an issued instruction is OP_JMP with im equal to the current pc; that instruction SHALL still issue, then the block SHALL enter HALT and stop issuing.
REQ-026 In HALT, the block SHALL drive halted=1 and valid_out=0; when run=0 it SHALL go to IDLE with the PC unchanged.
REQ-027 The block SHALL drive valid_out=0 in every cycle with no issue, and op_out and im_out SHALL hold their last values.
REQ-028 A prog_we in the cycle that IDLE goes to RUN SHALL complete the write, and a fetch from that address in the next cycle SHALL return the new data.

Reset
REQ-029 When reset_n=0, the block SHALL immediately enter IDLE and drive pc=0, op_out=0, im_out=0, valid_out=0, halted=0, and clear all memory words to 0x00.
REQ-030 A reset asserted during RUN, STEP or HALT SHALL abort the operation with no partial issue, and the block SHALL restart in IDLE.

Structure
REQ-031 The opcode constants OP_JMP (4'b1111), OP_JNC (4'b1110) and OP_NOP SHALL live in the shared defines file used by the decoder, and the state encodings SHALL be local to the block.
REQ-032 The PC and next-PC logic SHALL be one natural sub-module, pc_next, which is combinational.

Verification
REQ-033 The bench SHALL load mem[0..2]={0x31,0x52,0x00}, pulse run for 3 cycles, and check op_out/im_out = 3/1, 5/2, 0/0 with valid_out=1 and pc_out = 1, 2, 3.
REQ-034 The bench SHALL load mem[0]=0xF5 (JMP 5) and mem[5]=0x12, run, and check that the second issue is op 1 / im 2 and that pc_out=6.
REQ-035 The bench SHALL load mem[0]=0xE7 (JNC 7) and check that carry_in=1 gives pc_out=1, and that after reset and a rerun carry_in=0 gives pc_out=7.
REQ-036 The bench SHALL load mem[4]=0xF4, set the PC to 4 via pc_clr followed by steps, run, and check one issue, then halted=1 and valid_out=0 while run stays high.
REQ-037 The bench SHALL pulse step with run=0 and check exactly one valid_out cycle, then IDLE; a prog_we while in RUN SHALL be checked to leave memory unchanged.
REQ-038 The bench SHALL drop reset_n mid-RUN and check that every output is 0 immediately, without waiting for a clock edge.
